// File: rtl/control_step_sequencer.sv
// control_step_sequencer
//   Moore control-step sequencer for the fetch cycle (T0-T2) and the execute
//   steps of register-register ALU instructions. It drives the datapath
//   bus-select and load strobes, waits for memory with a timeout, and
//   handles NOP, HALT and a sticky fault.
//
//   Optional feature macro: SINGLE_STEP_EN
//     defined   -> adds input step_i. Every state transition, including
//                  leaving IDLE, needs step_i=1 on that clock. The T1 timeout
//                  counter pauses while step_i=0.
//     undefined -> transitions happen on every clock.
//
// Ports
//   clk          system clock, rising edge
//   clr          asynchronous active-low reset
//   run_i        level, high = execute instructions continuously
//   step_i       (SINGLE_STEP_EN only) single-step advance enable
//   ir           IR contents, stable from T3 onward
//   mem_ready    memory read data valid
//   step         one-hot current step (bit k = Tk), zero outside T0..T5
//   pc_out, mar_in, inc_pc, z_in            T0 strobes
//   zlo_out, pc_in, md_read, mdr_in         T1 strobes (zlo_out also execute)
//   mdr_out, ir_in                          T2 strobes
//   y_in         Y register load
//   alu_op       ALU function select, 0 outside the ALU step
//   reg_out_sel  one-hot register-to-bus select
//   reg_in_en    one-hot register load enable
//   busy         high in any Tk state
//   done         pulse in the final step of each instruction
//   fault        sticky fault, cleared only by clr
module control_step_sequencer #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int STEP_W  = 8,
  parameter int MEM_TO  = 15
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               run_i,
`ifdef SINGLE_STEP_EN
  input  logic               step_i,
`endif
  input  logic [DATA_W-1:0]  ir,
  input  logic               mem_ready,
  output logic [STEP_W-1:0]  step,
  output logic               pc_out,
  output logic               mar_in,
  output logic               inc_pc,
  output logic               z_in,
  output logic               zlo_out,
  output logic               pc_in,
  output logic               md_read,
  output logic               mdr_in,
  output logic               mdr_out,
  output logic               ir_in,
  output logic               y_in,
  output logic [4:0]         alu_op,
  output logic [REG_CNT-1:0] reg_out_sel,
  output logic [REG_CNT-1:0] reg_in_en,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam int CNT_W = $clog2(MEM_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT, S_FAULT
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             advance;

`ifdef SINGLE_STEP_EN
  assign advance = step_i;
`else
  assign advance = 1'b1;
`endif

  // IR field decode
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_un, is_nop, is_halt;
  logic       ra_bad, rb_bad, rc_bad;
  logic       unused_ir;

  assign opcode  = ir[31:27];
  assign ra      = ir[26:23];
  assign rb      = ir[22:19];
  assign rc      = ir[18:15];
  assign unused_ir = ^ir;
  assign is_bin  = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_un   = (opcode == 5'd16) || (opcode == 5'd17);
  assign is_nop  = (opcode == 5'd0);
  assign is_halt = (opcode == 5'd31);
  assign ra_bad  = 32'(ra) >= 32'(REG_CNT);
  assign rb_bad  = 32'(rb) >= 32'(REG_CNT);
  assign rc_bad  = 32'(rc) >= 32'(REG_CNT);

  // State register and T1 wait counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else if (advance) begin
      wait_cnt_reg <= '0;
      case (state_reg)
        S_IDLE: if (run_i) state_reg <= S_T0;
        S_T0:   state_reg <= S_T1;
        S_T1: begin
          // mem_ready wins over the timeout on the last allowed cycle
          if (mem_ready)                   state_reg <= S_T2;
          else if (wait_cnt_reg == CNT_LAST) state_reg <= S_FAULT;
          else                             wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
        S_T2:   state_reg <= S_T3;
        S_T3: begin
          if (is_bin || is_un) state_reg <= rb_bad ? S_FAULT : S_T4;
          else if (is_nop)     state_reg <= run_i ? S_T0 : S_IDLE;
          else if (is_halt)    state_reg <= S_HALT;
          else                 state_reg <= S_FAULT;
        end
        S_T4: begin
          if (is_bin)     state_reg <= rc_bad ? S_FAULT : S_T5;
          else if (is_un) state_reg <= ra_bad ? S_FAULT : (run_i ? S_T0 : S_IDLE);
          else            state_reg <= S_FAULT;
        end
        S_T5: begin
          if (is_bin && !ra_bad) state_reg <= run_i ? S_T0 : S_IDLE;
          else                   state_reg <= S_FAULT;
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_FAULT;
      endcase
    end
  end

  // Output decode from registered state plus ir; a step whose register
  // field is out of range drives no strobes before entering FAULT.
  logic       rsel_en, ren_en;
  logic [3:0] rsel_idx, ren_idx;
  logic       step_vld;
  logic [2:0] step_idx;

  always_comb begin
    pc_out = 1'b0; mar_in = 1'b0; inc_pc = 1'b0; z_in = 1'b0;
    zlo_out = 1'b0; pc_in = 1'b0; md_read = 1'b0; mdr_in = 1'b0;
    mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; alu_op = 5'd0;
    rsel_en = 1'b0; rsel_idx = rb; ren_en = 1'b0; ren_idx = ra;
    done = 1'b0; step_vld = 1'b1; step_idx = 3'd0;
    case (state_reg)
      S_T0: begin
        step_idx = 3'd0;
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
      end
      S_T1: begin
        step_idx = 3'd1;
        md_read = 1'b1; mdr_in = 1'b1;
        // PC update only on the first T1 cycle so pc_in pulses once per fetch
        if (wait_cnt_reg == '0) begin
          zlo_out = 1'b1; pc_in = 1'b1;
        end
      end
      S_T2: begin
        step_idx = 3'd2;
        mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        step_idx = 3'd3;
        if (is_bin && !rb_bad) begin
          rsel_en = 1'b1; y_in = 1'b1;
        end else if (is_un && !rb_bad) begin
          rsel_en = 1'b1; alu_op = opcode; z_in = 1'b1;
        end else if (is_nop || is_halt) begin
          done = 1'b1;
        end
      end
      S_T4: begin
        step_idx = 3'd4;
        if (is_bin && !rc_bad) begin
          rsel_en = 1'b1; rsel_idx = rc; alu_op = opcode; z_in = 1'b1;
        end else if (is_un && !ra_bad) begin
          zlo_out = 1'b1; ren_en = 1'b1; done = 1'b1;
        end
      end
      S_T5: begin
        step_idx = 3'd5;
        if (is_bin && !ra_bad) begin
          zlo_out = 1'b1; ren_en = 1'b1; done = 1'b1;
        end
      end
      default: step_vld = 1'b0;
    endcase
  end

  assign busy  = step_vld;
  assign fault = (state_reg == S_FAULT);

  genvar gi;
  generate
    for (gi = 0; gi < REG_CNT; gi++) begin : g_reg_dec
      assign reg_out_sel[gi] = rsel_en && (32'(rsel_idx) == 32'(gi));
      assign reg_in_en[gi]   = ren_en  && (32'(ren_idx)  == 32'(gi));
    end
    for (gi = 0; gi < STEP_W; gi++) begin : g_step_dec
      assign step[gi] = step_vld && (32'(step_idx) == 32'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_control_step_sequencer.sv
// tb_control_step_sequencer
//   Directed bench for control_step_sequencer. Each instruction's expected
//   per-cycle outputs and input drives are queued, then drained one cycle at
//   a time. A second instance with REG_CNT=4 covers the register-range fault.
module tb_control_step_sequencer;

  typedef struct packed {
    logic [7:0]  step;
    logic [10:0] strb;
    logic [4:0]  alu;
    logic [15:0] rsel;
    logic [15:0] ren;
    logic        busy;
    logic        done;
    logic        fault;
  } obs_t;

  // strobe bit positions inside obs_t.strb
  localparam logic [10:0] PC_OUT  = 11'h400;
  localparam logic [10:0] MAR_IN  = 11'h200;
  localparam logic [10:0] INC_PC  = 11'h100;
  localparam logic [10:0] Z_IN    = 11'h080;
  localparam logic [10:0] ZLO_OUT = 11'h040;
  localparam logic [10:0] PC_IN   = 11'h020;
  localparam logic [10:0] MD_READ = 11'h010;
  localparam logic [10:0] MDR_IN  = 11'h008;
  localparam logic [10:0] MDR_OUT = 11'h004;
  localparam logic [10:0] IR_IN   = 11'h002;
  localparam logic [10:0] Y_IN    = 11'h001;

  logic        clk, clr, clr2, run_i, mem_ready;
  logic [31:0] ir, ir2;
  logic [7:0]  step;
  logic        pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, md_read, mdr_in;
  logic        mdr_out, ir_in, y_in, busy, done, fault;
  logic [4:0]  alu_op;
  logic [15:0] reg_out_sel, reg_in_en;

  logic [7:0]  b_step;
  logic        b_pc_out, b_mar_in, b_inc_pc, b_z_in, b_zlo_out, b_pc_in, b_md_read, b_mdr_in;
  logic        b_mdr_out, b_ir_in, b_y_in, b_busy, b_done, b_fault;
  logic [4:0]  b_alu_op;
  logic [3:0]  b_rsel, b_ren;

  obs_t obs;
  int   checks = 0;
  int   errors = 0;
  logic check_b = 1'b0;

  obs_t     exp_q[$];
  string    tag_q[$];
  logic [1:0] drv_q[$];   // {run_i, mem_ready}

  initial clk = 1'b0;
  always #5 clk = ~clk;

  control_step_sequencer dut (
    .clk(clk), .clr(clr), .run_i(run_i),
`ifdef SINGLE_STEP_EN
    .step_i(1'b1),
`endif
    .ir(ir), .mem_ready(mem_ready), .step(step),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlo_out(zlo_out), .pc_in(pc_in), .md_read(md_read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .alu_op(alu_op),
    .reg_out_sel(reg_out_sel), .reg_in_en(reg_in_en),
    .busy(busy), .done(done), .fault(fault)
  );

  control_step_sequencer #(.REG_CNT(4)) dut_small (
    .clk(clk), .clr(clr2), .run_i(run_i),
`ifdef SINGLE_STEP_EN
    .step_i(1'b1),
`endif
    .ir(ir2), .mem_ready(mem_ready), .step(b_step),
    .pc_out(b_pc_out), .mar_in(b_mar_in), .inc_pc(b_inc_pc), .z_in(b_z_in),
    .zlo_out(b_zlo_out), .pc_in(b_pc_in), .md_read(b_md_read), .mdr_in(b_mdr_in),
    .mdr_out(b_mdr_out), .ir_in(b_ir_in), .y_in(b_y_in), .alu_op(b_alu_op),
    .reg_out_sel(b_rsel), .reg_in_en(b_ren),
    .busy(b_busy), .done(b_done), .fault(b_fault)
  );

  assign obs = {step, pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, md_read, mdr_in,
                mdr_out, ir_in, y_in, alu_op, reg_out_sel, reg_in_en, busy, done, fault};

  function automatic obs_t mk(input int idx, input logic [10:0] s, input logic [4:0] alu,
                              input logic [15:0] rsel, input logic [15:0] ren,
                              input logic dn, input logic flt);
    obs_t e;
    e.step  = (idx >= 0) ? (8'd1 << idx) : 8'd0;
    e.strb  = s;
    e.alu   = alu;
    e.rsel  = rsel;
    e.ren   = ren;
    e.busy  = (idx >= 0);
    e.done  = dn;
    e.fault = flt;
    return e;
  endfunction

  task automatic push(input string tag, input logic run, input logic mr, input obs_t e);
    tag_q.push_back(tag);
    drv_q.push_back({run, mr});
    exp_q.push_back(e);
  endtask

  task automatic push_zero(input string tag, input logic run, input logic mr);
    push(tag, run, mr, mk(-1, 11'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0));
  endtask

  task automatic push_fault(input string tag, input logic run, input logic mr);
    push(tag, run, mr, mk(-1, 11'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1));
  endtask

  // T0, T1 lasting lat+1 cycles (mem_ready on the last), T2
  task automatic push_fetch(input int lat, input logic run);
    push("t0", run, 1'b0, mk(0, PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0));
    for (int i = 0; i <= lat; i++)
      push((i == 0) ? "t1_first" : "t1_wait", run, (i == lat),
           mk(1, MD_READ | MDR_IN | ((i == 0) ? (ZLO_OUT | PC_IN) : 11'h0),
              5'd0, 16'h0, 16'h0, 1'b0, 1'b0));
    push("t2", run, 1'b0, mk(2, MDR_OUT | IR_IN, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0));
  endtask

  task automatic cmp(input string tag, input obs_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, e);
    end
    if (check_b) begin
      checks++;
      assert ({b_step, b_rsel, b_y_in, b_fault} === {e.step, e.rsel[3:0], 1'b0, e.fault}) else begin
        errors++;
        $error("FAIL %s_small: got %h expected %h", tag,
               {b_step, b_rsel, b_y_in, b_fault}, {e.step, e.rsel[3:0], 1'b0, e.fault});
      end
    end
    $display("txn %-18s step=%h strb=%h alu=%0d rsel=%h ren=%h busy=%b done=%b fault=%b",
             tag, obs.step, obs.strb, obs.alu, obs.rsel, obs.ren, obs.busy, obs.done, obs.fault);
  endtask

  // compare the oldest queued expectation right now, without clocking
  task automatic check_now();
    string t;
    logic [1:0] d;
    t = tag_q.pop_front();
    d = drv_q.pop_front();
    cmp(t, exp_q.pop_front());
  endtask

  // one queued entry per clock: drive after the edge, sample on the falling edge
  task automatic drain();
    string t;
    obs_t  e;
    while (exp_q.size() > 0) begin
      {run_i, mem_ready} = drv_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      cmp(t, e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clr = 1'b0; clr2 = 1'b0; run_i = 1'b0; mem_ready = 1'b0;
    #1;
    push_zero("reset_clear", 1'b0, 1'b0);
    check_now();
    @(posedge clk); #1;
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0; clr2 = 1'b0; run_i = 1'b0; mem_ready = 1'b0;
    ir = 32'h0; ir2 = 32'h28A98000;   // op5, Ra=1, Rb=5 (out of range for REG_CNT=4), Rc=3
    @(posedge clk); #1;
    push_zero("power_on_reset", 1'b0, 1'b0);
    check_now();
    @(posedge clk); #1;
    clr = 1'b1;

    // binary op5: Ra=1 Rb=2 Rc=3, six busy cycles
    ir = 32'h28918000;
    push_zero("idle_start", 1'b1, 1'b0);
    push_fetch(0, 1'b1);
    push("bin_t3", 1'b1, 1'b0, mk(3, Y_IN, 5'd0, 16'h0004, 16'h0, 1'b0, 1'b0));
    push("bin_t4", 1'b1, 1'b0, mk(4, Z_IN, 5'd5, 16'h0008, 16'h0, 1'b0, 1'b0));
    push("bin_t5", 1'b1, 1'b0, mk(5, ZLO_OUT, 5'd0, 16'h0, 16'h0002, 1'b1, 1'b0));
    drain();

    // NEG back-to-back, run held
    ir = 32'h80918000;
    push_fetch(0, 1'b1);
    push("neg_t3", 1'b1, 1'b0, mk(3, Z_IN, 5'd16, 16'h0004, 16'h0, 1'b0, 1'b0));
    push("neg_t4", 1'b1, 1'b0, mk(4, ZLO_OUT, 5'd0, 16'h0, 16'h0002, 1'b1, 1'b0));
    drain();

    // NOP, mem_ready delayed 3 cycles, run dropped mid-instruction
    ir = 32'h00000000;
    push_fetch(3, 1'b0);
    push("nop_t3", 1'b0, 1'b0, mk(3, 11'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
    push_zero("idle_after_nop", 1'b0, 1'b0);
    push_zero("idle_hold", 1'b0, 1'b0);
    drain();

    // illegal opcode 0x0C, alongside Rb out of range on the small instance
    ir = 32'h60000000;
    clr2 = 1'b1;
    check_b = 1'b1;
    push_zero("idle_illegal", 1'b1, 1'b0);
    push_fetch(1, 1'b1);
    push("illegal_t3", 1'b1, 1'b0, mk(3, 11'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0));
    push_fault("fault_a", 1'b0, 1'b0);
    push_fault("fault_b", 1'b1, 1'b1);
    push_fault("fault_c", 1'b1, 1'b0);
    drain();
    check_b = 1'b0;
    do_reset();

    // HALT: done in T3, then frozen regardless of run_i
    ir = 32'hF8000000;
    push_zero("idle_halt", 1'b1, 1'b0);
    push_fetch(0, 1'b1);
    push("halt_t3", 1'b1, 1'b0, mk(3, 11'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
    push_zero("halted_a", 1'b0, 1'b0);
    push_zero("halted_b", 1'b1, 1'b1);
    push_zero("halted_c", 1'b0, 1'b0);
    push_zero("halted_d", 1'b1, 1'b0);
    drain();
    do_reset();

    // memory timeout: 15 T1 cycles without mem_ready, then FAULT
    ir = 32'h28918000;
    push_zero("idle_timeout", 1'b1, 1'b0);
    push("to_t0", 1'b1, 1'b0, mk(0, PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0));
    for (int i = 0; i < 15; i++)
      push((i == 0) ? "to_t1_first" : "to_t1_wait", 1'b1, 1'b0,
           mk(1, MD_READ | MDR_IN | ((i == 0) ? (ZLO_OUT | PC_IN) : 11'h0),
              5'd0, 16'h0, 16'h0, 1'b0, 1'b0));
    push_fault("timeout_fault", 1'b1, 1'b1);
    push_fault("timeout_sticky", 1'b1, 1'b0);
    drain();
    do_reset();

    // asynchronous reset in the middle of T4
    push_zero("idle_rst", 1'b1, 1'b0);
    push_fetch(0, 1'b1);
    push("rst_t3", 1'b1, 1'b0, mk(3, Y_IN, 5'd0, 16'h0004, 16'h0, 1'b0, 1'b0));
    drain();
    push("rst_t4", 1'b1, 1'b0, mk(4, Z_IN, 5'd5, 16'h0008, 16'h0, 1'b0, 1'b0));
    check_now();
    #2;
    clr = 1'b0;
    #1;
    push_zero("reset_mid_t4", 1'b1, 1'b0);
    check_now();
    @(posedge clk); #1;
    push_zero("reset_held", 1'b1, 1'b0);
    check_now();
    clr = 1'b1;
    push_zero("idle_release", 1'b1, 1'b0);
    push_fetch(0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_step_sequencer.md
Name: control_step_sequencer

Overview:
Parametrised control-step sequencer that drives the datapath through the fetch cycle (T0-T2) and the execute steps for register-register ALU instructions.
- Replaces hand-driven bus-select/enable strobes with a clocked Moore FSM.
- Adds a memory-ready wait with timeout, an unary/binary execute split, NOP/HALT handling and a sticky fault.
- Sits between the IR/memory interface and the datapath select/enable inputs.

Parameters:
DATA_W, 32, datapath and IR width
REG_CNT, 16, number of general registers; width of one-hot select/enable vectors
STEP_W, 8, width of one-hot step output; must be >= 6
MEM_TO, 15, max cycles T1 waits for mem_ready before fault

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
run_i  in  1  level; high = execute instructions continuously
ir  in  DATA_W  current IR register contents; stable from T3 onward
mem_ready  in  1  memory read data valid on MDataIn
step  out  STEP_W  one-hot current step, bit k = Tk; all-zero in IDLE/HALT/FAULT
pc_out, mar_in, inc_pc, z_in  out  1 each  T0 strobes
zlo_out, pc_in, md_read, mdr_in  out  1 each  T1 strobes (zlo_out also used in execute)
mdr_out, ir_in  out  1 each  T2 strobes
y_in  out  1  Y register load
alu_op  out  5  ALU function select; 0 when not in the ALU step
reg_out_sel  out  REG_CNT  one-hot register-to-bus select
reg_in_en  out  REG_CNT  one-hot register load enable
busy  out  1  high in any Tk state
done  out  1  one-cycle pulse in the final step of each instruction
fault  out  1  sticky; cleared only by clr

Behaviour:
- Reset (clr=0, asynchronous): state IDLE; all outputs 0; wait counter 0. Reset mid-instruction aborts it immediately with no further strobes.
- IR fields: opcode = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15]. Any used field >= REG_CNT -> FAULT on the step that would use it.
- IDLE: go to T0 on the first clk with run_i=1.
- T0 (1 cycle): pc_out, mar_in, inc_pc, z_in = 1. Next state T1.
- T1: zlo_out, pc_in, md_read, mdr_in = 1 for the first cycle only; after that, md_read and mdr_in only.
  - Leave on the cycle mem_ready=1 (that cycle's mdr_in captures the data).
  - MEM_TO cycles without mem_ready -> FAULT.
  - pc_in pulses exactly once per fetch.
- T2 (1 cycle): mdr_out, ir_in = 1. Next state T3.
- T3, decoded by opcode:
  - Binary ops 3..11: reg_out_sel[Rb], y_in -> T4; then reg_out_sel[Rc], alu_op=opcode, z_in -> T5; then zlo_out, reg_in_en[Ra] -> end.
  - Unary ops 16 (NEG), 17 (NOT): reg_out_sel[Rb], alu_op=opcode, z_in -> T4; then zlo_out, reg_in_en[Ra] -> end.
  - 0 (NOP): end in T3 with no strobes.
  - 31 (HALT): done pulse in T3, then HALT.
  - Any other opcode: FAULT.
- End of instruction: done=1 in the final step. Next state T0 if run_i=1, else IDLE. There are no idle cycles between back-to-back instructions.
- HALT: leave only via clr; run_i is ignored.
- FAULT: fault=1 and every strobe 0 until clr.
- run_i falling mid-instruction: the instruction completes, then IDLE.
- At most one bit of reg_out_sel is set per cycle and never together with pc_out, zlo_out or mdr_out. Same rule for reg_in_en versus the other bus-load strobes.
- All outputs are decoded from registered state plus the ir input; there are no combinational paths from mem_ready or run_i to the outputs.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input step_i (1 bit). Every state transition (including leaving IDLE) also requires step_i=1 on that clk, so each pulse advances exactly one step. The T1 timeout counter pauses while step_i=0. Strobes stay asserted while the state is held.
- Undefined: no step_i port; transitions occur every cycle as above.

Test Plan:
- Reset: clr low mid-T4 -> all outputs 0, step=0 the same instant; after release with run_i=1, T0 at the next edge.
- Binary: ir=0x28918000 (op5, Ra=1, Rb=2, Rc=3), mem_ready at first T1 cycle ->
  - T3: reg_out_sel=0x0004 with y_in.
  - T4: reg_out_sel=0x0008, alu_op=5, z_in.
  - T5: zlo_out, reg_in_en=0x0002, done.
  - 6 cycles total.
- NEG: ir=0x80918000 (op16, Ra=1, Rb=2), run_i held -> T4 asserts reg_in_en=0x0002 and done, and T0 follows on the next cycle.
- Memory wait: mem_ready delayed 3 cycles -> T1 lasts 4 cycles and pc_in pulses once. mem_ready never asserted -> fault=1 after 15 cycles, all strobes 0.
- Illegal opcode 0x0C -> fault at T3. With REG_CNT=4, Rb=5 -> fault at T3.
- HALT: op31 -> done in T3, then step=0, busy=0; toggling run_i has no effect until clr.
